// File: rtl/instr_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_pkg
// Description : Shared constants, load-FSM state type and parity helper for
//               the loadable instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_mem_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    LOAD = 1'b1
  } load_state_t;

  // Even parity over a word zero-extended to 64 bits (zero-extension leaves
  // the parity unchanged, so any instruction width up to 64 bits fits).
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader
// Description : Serial program-load controller. Owns the RUN/LOAD FSM and the
//               write pointer, and emits one memory write per accepted beat.
//               A load ends on a HALT word or on the beat written at the last
//               address.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int INSTR_W = 32,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_ready,
  output logic               load_busy,
  output logic               load_done,
  output logic               wr_en,
  output logic [PTR_W-1:0]   wr_addr,
  output logic [INSTR_W-1:0] wr_data
);

  localparam logic [PTR_W-1:0]   c_LAST = PTR_W'(DEPTH - 1);
  localparam logic [INSTR_W-1:0] c_HALT = INSTR_W'(HALT_INSTR);

  load_state_t      r_state;
  load_state_t      w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             r_done;
  logic             w_done_nxt;

  // State, pointer and done-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_ptr   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state, pointer advance, write strobe and termination detection.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_done_nxt  = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = r_ptr;
    wr_data     = load_data;
    load_ready  = 1'b0;
    load_busy   = 1'b0;
    case (r_state)
      RUN: begin
        if (load_start) begin
          w_state_nxt = LOAD;
          w_ptr_nxt   = '0;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        load_busy  = 1'b1;
        if (load_valid) begin
          wr_en = 1'b1;
          // The pointer parks at zero instead of wrapping past the last word.
          if ((load_data == c_HALT) || (r_ptr == c_LAST)) begin
            w_state_nxt = RUN;
            w_ptr_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_ptr_nxt = r_ptr + PTR_W'(1);
          end
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign load_done = r_done;

endmodule
`default_nettype wire

// File: rtl/instr_mem_loadable.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loadable
// Description : Run-time loadable instruction memory with registered,
//               stall-aware fetch and sticky halt detection.
//               Optional feature macro: INSTR_PARITY_EN (per-word even parity
//               and a registered parity_err output).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 32,   // 2 <= DEPTH <= 2**ADDR_W
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  input  logic               stall,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               halt_seen,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_ready,
  output logic               load_busy,
  output logic               load_done
`ifdef INSTR_PARITY_EN
  ,
  output logic               parity_err
`endif
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam logic [INSTR_W-1:0] c_NOP   = INSTR_W'(NOP_INSTR);
  localparam logic [INSTR_W-1:0] c_HALT  = INSTR_W'(HALT_INSTR);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic               w_wr_en;
  logic [c_PTR_W-1:0] w_wr_addr;
  logic [INSTR_W-1:0] w_wr_data;
  logic [c_PTR_W-1:0] w_idx;
  logic               w_in_range;
  logic               w_start;
  logic [INSTR_W-1:0] w_fetch_word;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic               r_halt;

  instr_mem_loader #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W),
    .PTR_W   (c_PTR_W)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .wr_en      (w_wr_en),
    .wr_addr    (w_wr_addr),
    .wr_data    (w_wr_data)
  );

  // A load request is only honoured while running; it pre-empts any fetch.
  assign w_start    = load_start && !load_busy;
  assign w_idx      = fetch_addr[c_PTR_W-1:0];
  assign w_in_range = (32'(fetch_addr) < 32'(DEPTH));

  // Instruction array: cleared to NOP on reset, written only by the loader.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= c_NOP;
    end else if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  // Addressed word, or NOP when the address lies past the populated depth.
  always_comb begin
    w_fetch_word = c_NOP;
    if (w_in_range) w_fetch_word = r_mem[w_idx];
  end

  // Fetch register: cleared while loading, frozen under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= c_NOP;
      r_valid <= 1'b0;
    end else if (w_start || load_busy) begin
      r_instr <= c_NOP;
      r_valid <= 1'b0;
    end else if (!stall) begin
      if (fetch_req) begin
        r_instr <= w_fetch_word;
        r_valid <= 1'b1;
      end else begin
        r_instr <= c_NOP;
        r_valid <= 1'b0;
      end
    end
  end

  // Sticky halt flag, raised the cycle after HALT sits in the fetch register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halt <= 1'b0;
    end else if (w_start) begin
      r_halt <= 1'b0;
    end else if (r_instr == c_HALT) begin
      r_halt <= 1'b1;
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign halt_seen   = r_halt;

`ifdef INSTR_PARITY_EN
  localparam logic c_NOP_PAR = even_parity(64'(c_NOP));

  logic r_par [DEPTH];
  logic w_par_bad;
  logic r_perr;

  // Parity side-array, written alongside the data word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_par[i] <= c_NOP_PAR;
    end else if (w_wr_en) begin
      r_par[w_wr_addr] <= even_parity(64'(w_wr_data));
    end
  end

  // Stored parity disagrees with the word read back (in-range only).
  always_comb begin
    w_par_bad = 1'b0;
    if (w_in_range) w_par_bad = (r_par[w_idx] != even_parity(64'(r_mem[w_idx])));
  end

  // Parity error register, tracking the fetch register cycle for cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr <= 1'b0;
    end else if (w_start || load_busy) begin
      r_perr <= 1'b0;
    end else if (!stall) begin
      r_perr <= fetch_req && w_par_bad;
    end
  end

  assign parity_err = r_perr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loadable.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_loadable
// Description : Self-checking bench for instr_mem_loadable. Two instances
//               (DEPTH 32 and DEPTH 20) share stimulus; a behavioural model
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loadable;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req, stall, load_start, load_valid;
  logic [4:0]  fetch_addr;
  logic [31:0] load_data;

  logic [31:0] instr0, instr1;
  logic        valid0, valid1, halt0, halt1, ready0, ready1;
  logic        busy0, busy1, done0, done1;
`ifdef INSTR_PARITY_EN
  logic        perr0, perr1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_mem_loadable #(.ADDR_W(5), .DEPTH(32), .INSTR_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .stall(stall), .instr(instr0), .instr_valid(valid0), .halt_seen(halt0),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(ready0), .load_busy(busy0), .load_done(done0)
`ifdef INSTR_PARITY_EN
    , .parity_err(perr0)
`endif
  );

  instr_mem_loadable #(.ADDR_W(5), .DEPTH(20), .INSTR_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .stall(stall), .instr(instr1), .instr_valid(valid1), .halt_seen(halt1),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(ready1), .load_busy(busy1), .load_done(done1)
`ifdef INSTR_PARITY_EN
    , .parity_err(perr1)
`endif
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [2][32];
  bit          m_load [2];
  int          m_ptr  [2];
  logic [31:0] e_instr [2];
  bit          e_valid [2], e_halt [2], e_done [2];

  function automatic int depth_of(int d);
    return (d == 0) ? 32 : 20;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 32; a++) m_mem[d][a] = NOP;
      m_load[d] = 0; m_ptr[d] = 0;
      e_instr[d] = NOP; e_valid[d] = 0; e_halt[d] = 0; e_done[d] = 0;
    end
  endtask

  task automatic model_step(int d);
    bit halt_next;
    halt_next = e_halt[d] || (e_instr[d] == HALT);
    e_done[d] = 0;
    if (!m_load[d]) begin
      if (load_start) begin
        m_load[d] = 1; m_ptr[d] = 0;
        e_instr[d] = NOP; e_valid[d] = 0; e_halt[d] = 0;
      end else begin
        e_halt[d] = halt_next;
        if (!stall) begin
          if (fetch_req) begin
            e_instr[d] = (int'(fetch_addr) < depth_of(d)) ? m_mem[d][fetch_addr] : NOP;
            e_valid[d] = 1;
          end else begin
            e_instr[d] = NOP; e_valid[d] = 0;
          end
        end
      end
    end else begin
      e_halt[d] = halt_next;
      e_instr[d] = NOP; e_valid[d] = 0;
      if (load_valid) begin
        m_mem[d][m_ptr[d]] = load_data;
        if (load_data == HALT || m_ptr[d] == depth_of(d) - 1) begin
          m_load[d] = 0; m_ptr[d] = 0; e_done[d] = 1;
        end else begin
          m_ptr[d]++;
        end
      end
    end
  endtask

  // Model advances on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else for (int d = 0; d < 2; d++) model_step(d);
  end

  // ---------------- checking ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_inst(int d, logic [31:0] i, logic v, logic h, logic r, logic b, logic dn);
    chk($sformatf("dut%0d.instr", d),       i,  e_instr[d]);
    chk($sformatf("dut%0d.instr_valid", d), {31'b0, v},  {31'b0, e_valid[d]});
    chk($sformatf("dut%0d.halt_seen", d),   {31'b0, h},  {31'b0, e_halt[d]});
    chk($sformatf("dut%0d.load_ready", d),  {31'b0, r},  {31'b0, m_load[d]});
    chk($sformatf("dut%0d.load_busy", d),   {31'b0, b},  {31'b0, m_load[d]});
    chk($sformatf("dut%0d.load_done", d),   {31'b0, dn}, {31'b0, e_done[d]});
  endtask

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clk) begin
    chk_inst(0, instr0, valid0, halt0, ready0, busy0, done0);
    chk_inst(1, instr1, valid1, halt1, ready1, busy1, done1);
`ifdef INSTR_PARITY_EN
    chk("dut0.parity_err", {31'b0, perr0}, 32'd0);
    chk("dut1.parity_err", {31'b0, perr1}, 32'd0);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_req = 0; fetch_addr = '0; stall = 0;
    load_start = 0; load_valid = 0; load_data = '0;
  endtask

  task automatic fetch(int a);
    fetch_req = 1; fetch_addr = 5'(a); cyc();
  endtask

  function automatic logic [31:0] nonhalt();
    logic [31:0] v;
    v = $urandom;
    if (v == HALT) v = 32'h0;
    return v;
  endfunction

  initial begin
    idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("reset instr", instr0, NOP);
    chk("reset valid", {31'b0, valid0}, 32'd0);
    chk("reset busy",  {31'b0, busy0},  32'd0);

    // Fresh memory reads back NOP everywhere.
    for (int a = 0; a < 32; a++) begin
      fetch(a);
      chk("scan nop", instr0, NOP);
    end
    idle(); cyc();
    chk("scan halt_seen", {31'b0, halt0}, 32'd0);

    // Three-word program ending in HALT.
    load_start = 1; cyc(); load_start = 0;
    load_valid = 1;
    load_data = 32'h0060_0513; cyc();
    load_data = 32'h00c0_00ef; cyc();
    load_data = HALT;          cyc();
    load_valid = 0;
    chk("short load_done", {31'b0, done0}, 32'd1);
    fetch(0); chk("prog word0", instr0, 32'h0060_0513);
    fetch(1); chk("prog word1", instr0, 32'h00c0_00ef);
    fetch(2); chk("prog word2", instr0, HALT);
    chk("halt not yet", {31'b0, halt0}, 32'd0);
    fetch(1); chk("halt set", {31'b0, halt0}, 32'd1);

    // Stall freezes the fetch output.
    fetch(1);
    stall = 1; fetch_addr = 5'd0;
    repeat (3) begin
      cyc();
      chk("stall hold", instr0, 32'h00c0_00ef);
    end
    stall = 0;
    fetch(0); chk("after stall", instr0, 32'h0060_0513);

    // load_start with fetch_req: load wins; then a full-depth load.
    fetch_req = 1; fetch_addr = 5'd2; load_start = 1; cyc();
    chk("collide valid", {31'b0, valid0}, 32'd0);
    chk("collide busy",  {31'b0, busy0},  32'd1);
    chk("collide halt",  {31'b0, halt0},  32'd0);
    idle();
    for (int i = 0; i < 33; i++) begin
      load_valid = 1; load_data = nonhalt(); cyc();
      if (i == 31) chk("full load_done", {31'b0, done0}, 32'd1);
    end
    idle();
    chk("33rd beat busy", {31'b0, busy0}, 32'd0);
    for (int a = 0; a < 32; a++) fetch(a);
    fetch(25);
    chk("depth20 oor instr", instr1, NOP);
    chk("depth20 oor valid", {31'b0, valid1}, 32'd1);

    // Randomised traffic.
    idle();
    for (int n = 0; n < 1500; n++) begin
      load_start = ($urandom_range(0, 39) == 0);
      load_valid = $urandom_range(0, 1);
      load_data  = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
      fetch_req  = ($urandom_range(0, 3) != 0);
      fetch_addr = 5'($urandom_range(0, 31));
      stall      = ($urandom_range(0, 3) == 0);
      cyc();
    end

    // Bring both instances back to RUN, then reset in the middle of a load.
    idle();
    load_valid = 1; load_data = HALT; cyc();
    idle(); cyc();
    load_start = 1; cyc(); load_start = 0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1; load_data = nonhalt(); cyc();
    end
    idle();
    rst_n = 0;
    #1;
    chk("midload reset busy",  {31'b0, busy0}, 32'd0);
    chk("midload reset instr", instr0, NOP);
    @(posedge clk);
    #1 rst_n = 1;
    for (int a = 0; a < 32; a++) begin
      fetch(a);
      chk("post-reset nop", instr0, NOP);
    end
    idle(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
